// File: rtl/fsm_deshift.sv
// Serial-to-parallel reassembly stage: rebuilds WIDTH-bit words from a strobed bit stream.
// Optional even-parity check state is enabled by defining FSM_DESHIFT_PARITY_EN.
module fsm_deshift #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_bit_valid,
    input  logic             i_serial_in,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             o_out_valid,
    output logic             o_busy,
`ifdef FSM_DESHIFT_PARITY_EN
    output logic             o_parity_err,
`endif
    output logic [1:0]       o_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_HOLD   = 2'd2,
        S_PARITY = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_shreg;
    logic [WIDTH-1:0]  r_out;
    logic              r_out_valid;
    logic [WIDTH-1:0]  w_shifted;
    logic              w_last;
`ifdef FSM_DESHIFT_PARITY_EN
    logic              r_parity_err;
`endif

    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], i_serial_in}
                                 : {i_serial_in, r_shreg[WIDTH-1:1]};
    assign w_last    = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Output handshake: a word is transferred on any edge where o_out_valid and
    // i_out_ready are both high; o_out and o_out_valid stay put until then.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_SHIFT;
            S_SHIFT: begin
                if (i_bit_valid && w_last) begin
`ifdef FSM_DESHIFT_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_HOLD;
`endif
                end
            end
            S_PARITY: if (i_bit_valid) w_next = S_HOLD;
            S_HOLD:   if (i_out_ready) w_next = i_start ? S_SHIFT : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state != S_IDLE);
        o_state = r_state;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
`ifdef FSM_DESHIFT_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= '0;
                        r_shreg <= '0;
                    end
                end
                S_SHIFT: begin
                    if (i_bit_valid) begin
                        r_shreg <= w_shifted;
                        if (w_last) begin
                            r_out <= w_shifted;
                            r_cnt <= '0;
`ifndef FSM_DESHIFT_PARITY_EN
                            r_out_valid <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef FSM_DESHIFT_PARITY_EN
                S_PARITY: begin
                    if (i_bit_valid) begin
                        r_parity_err <= (^r_out) ^ i_serial_in;
                        r_out_valid  <= 1'b1;
                    end
                end
`endif
                S_HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
`ifdef FSM_DESHIFT_PARITY_EN
                        r_parity_err <= 1'b0;
`endif
                        if (i_start) begin
                            r_cnt   <= '0;
                            r_shreg <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
`ifdef FSM_DESHIFT_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule
